uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 14 +
 rtl/uart_tx_scheduler_if.sv | 30 +++
 rtl/uart_tx_scheduler_fifo.sv | 59 +++++
 rtl/uart_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler: drain FSM states,
// default CPU transmit-register address and default ASCII offset.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } drain_state_e;

  localparam logic [31:0] DEFAULT_MMIO_ADDR    = 32'h0000_2000;
  localparam logic [7:0]  DEFAULT_ASCII_OFFSET = 8'h30;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of CPU write port, debug byte port, uart_tx handshake and FIFO level.
// The slave modport is the scheduler's view; master is the surrounding system.
interface uart_tx_scheduler_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wrdata;
  logic               cpu_memwrite;
  logic               cpu_stall;
  logic               dbg_valid;
  logic [7:0]         dbg_data;
  logic               dbg_ready;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_ready;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output cpu_addr, cpu_wrdata, cpu_memwrite, dbg_valid, dbg_data, tx_ready,
    input  cpu_stall, dbg_ready, tx_data, tx_start, fifo_level
  );

  modport slave (
    input  cpu_addr, cpu_wrdata, cpu_memwrite, dbg_valid, dbg_data, tx_ready,
    output cpu_stall, dbg_ready, tx_data, tx_start, fifo_level
  );

endinterface

// File: rtl/uart_tx_scheduler_fifo.sv
// Byte FIFO for the UART scheduler: power-of-two depth, same-cycle push/pop
// allowed (including when full), first-word-fall-through read data.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are valid, so stale data is never visible after a flush.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign level    = count;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates CPU MMIO writes and debug bytes into a byte FIFO and drains it into
// uart_tx. Define UART_TX_SCHED_ASCII_EN to add ASCII_OFFSET to CPU bytes.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] MMIO_ADDR    = DEFAULT_MMIO_ADDR,
  parameter logic [7:0]  ASCII_OFFSET = DEFAULT_ASCII_OFFSET
) (
  input logic                clk,
  input logic                rst,
  uart_tx_scheduler_if.slave bus
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               cpu_req;
  logic               dbg_req;
  logic               conflict;
  logic               cpu_win;
  logic               dbg_win;
  logic               can_push;
  logic               grant_cpu;
  logic               grant_dbg;
  logic               rr_dbg_turn;
  logic [7:0]         cpu_byte;
  logic               fifo_push;
  logic [7:0]         fifo_din;
  logic               fifo_pop;
  logic [7:0]         fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  drain_state_e       state;
  drain_state_e       state_n;
  logic [7:0]         tx_data_q;
  logic [7:0]         tx_data_n;
  logic               unused_wrdata_hi;

  assign unused_wrdata_hi = ^bus.cpu_wrdata[31:8];

`ifdef UART_TX_SCHED_ASCII_EN
  assign cpu_byte = bus.cpu_wrdata[7:0] + ASCII_OFFSET;
`else
  logic [7:0] unused_ascii_offset;
  assign unused_ascii_offset = ASCII_OFFSET;
  assign cpu_byte            = bus.cpu_wrdata[7:0];
`endif

  assign cpu_req  = bus.cpu_memwrite && (bus.cpu_addr == MMIO_ADDR);
  assign dbg_req  = bus.dbg_valid;
  assign conflict = cpu_req && dbg_req;

  // A pop in the same cycle frees the slot the push is about to use.
  assign can_push  = !fifo_full || fifo_pop;
  assign cpu_win   = cpu_req && (!dbg_req || !rr_dbg_turn);
  assign dbg_win   = dbg_req && (!cpu_req ||  rr_dbg_turn);
  assign grant_cpu = cpu_win && can_push;
  assign grant_dbg = dbg_win && can_push;

  assign fifo_push = grant_cpu || grant_dbg;
  assign fifo_din  = grant_cpu ? cpu_byte : bus.dbg_data;

  assign bus.cpu_stall = cpu_req && !grant_cpu;
  assign bus.dbg_ready = grant_dbg;

  // Priority flips only when a conflicting pair actually gets a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       rr_dbg_turn <= 1'b0;
    else if (conflict && can_push) rr_dbg_turn <= ~rr_dbg_turn;
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bus.fifo_level = fifo_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_data_q <= '0;
    end else begin
      state     <= state_n;
      tx_data_q <= tx_data_n;
    end
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_n   = state;
    tx_data_n = tx_data_q;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && bus.tx_ready) begin
          fifo_pop  = 1'b1;
          tx_data_n = fifo_dout;
          state_n   = ST_START;
        end
      end
      ST_START: begin
        if (!bus.tx_ready) state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tx_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // tx_start is the START state itself, so an async reset drops it at once.
  assign bus.tx_start = (state == ST_START);
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a vector table for arbitration and FIFO
// fill, plus hand-written sequences for latency, back-pressure, round-robin and reset.
module tb_uart_tx_scheduler;

  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_SCHED_ASCII_EN
  localparam logic [7:0] OFS = 8'h30;
`else
  localparam logic [7:0] OFS = 8'h00;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        dv;
    logic [7:0]  dd;
    logic        exp_stall;
    logic        exp_rdy;
    logic [2:0]  exp_lvl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [9];

  uart_tx_scheduler_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_tx_scheduler #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cb(input logic [7:0] d);
    return d + OFS;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [7:0] wd, input logic we,
                       input logic dv, input logic [7:0] dd);
    bus.cpu_addr     = addr;
    bus.cpu_wrdata   = {24'h0, wd};
    bus.cpu_memwrite = we;
    bus.dbg_valid    = dv;
    bus.dbg_data     = dd;
  endtask

  task automatic idle_inputs();
    drive(32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Behaves as uart_tx: waits (bounded) for tx_start, then goes busy one cycle.
  task automatic expect_tx(input string name, input logic [7:0] exp);
    int n;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start"}, bus.tx_start, 1'b1);
    check({name, "_data"}, bus.tx_data, exp);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    check({name, "_drop"}, bus.tx_start, 1'b0);
    check({name, "_hold"}, bus.tx_data, exp);
    bus.tx_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] c_cpu [4];
    logic [7:0] c_dbg [4];
    logic       c_grant_dbg [4];
    int         cnt;

    tbl[0] = '{32'h2004, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{32'h2000, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{32'h0000, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 3'd1};
    tbl[3] = '{32'h2000, 8'h07, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2};
    tbl[4] = '{32'h2000, 8'h01, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 3'd3};
    tbl[5] = '{32'h2000, 8'h02, 1'b1, 1'b1, 8'h43, 1'b1, 1'b1, 3'd4};
    tbl[6] = '{32'h2000, 8'h03, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd4};
    tbl[7] = '{32'h0000, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 3'd4};
    tbl[8] = '{32'h2000, 8'h04, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0, 3'd4};

    // Reset state
    do_reset();
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_level", bus.fifo_level, 3'd0);
    check("rst_stall", bus.cpu_stall, 1'b0);
    check("rst_dbg_ready", bus.dbg_ready, 1'b0);

    // One-cycle latency from push into empty FIFO to tx_start
    bus.tx_ready = 1'b1;
    drive(32'h2000, 8'h05, 1'b1, 1'b0, 8'h00);
    #1 check("lat_stall", bus.cpu_stall, 1'b0);
    @(negedge clk);
    idle_inputs();
    check("lat_level1", bus.fifo_level, 3'd1);
    check("lat_no_start_yet", bus.tx_start, 1'b0);
    @(negedge clk);
    check("lat_start", bus.tx_start, 1'b1);
    check("lat_data", bus.tx_data, cb(8'h05));
    check("lat_level0", bus.fifo_level, 3'd0);
    @(negedge clk);
    check("start_held_while_ready", bus.tx_start, 1'b1);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    check("start_dropped", bus.tx_start, 1'b0);
    check("data_stable_wait", bus.tx_data, cb(8'h05));
    bus.tx_ready = 1'b1;
    @(negedge clk);

    // Vector table with uart_tx busy so nothing drains
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].dv, tbl[i].dd);
      #1;
      check($sformatf("vec%0d_stall", i), bus.cpu_stall, tbl[i].exp_stall);
      check($sformatf("vec%0d_dbg_ready", i), bus.dbg_ready, tbl[i].exp_rdy);
      @(negedge clk);
      check($sformatf("vec%0d_level", i), bus.fifo_level, tbl[i].exp_lvl);
    end
    idle_inputs();
    bus.tx_ready = 1'b1;
    expect_tx("vec_out0", 8'h41);
    expect_tx("vec_out1", cb(8'h07));
    expect_tx("vec_out2", cb(8'h01));
    expect_tx("vec_out3", 8'h43);
    // Blocked conflict while full must not have moved the pointer: CPU wins
    drive(32'h2000, 8'h09, 1'b1, 1'b1, 8'h46);
    #1;
    check("rr_after_full_stall", bus.cpu_stall, 1'b0);
    check("rr_after_full_dbg", bus.dbg_ready, 1'b0);
    @(negedge clk);
    idle_inputs();
    expect_tx("rr_after_full_out", cb(8'h09));

    // Back-pressure: five writes while busy, fifth stalls until a pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'h2000, 8'h10 + 8'(i), 1'b1, 1'b0, 8'h00);
      #1 check($sformatf("bp_stall%0d", i), bus.cpu_stall, 1'b0);
      @(negedge clk);
    end
    drive(32'h2000, 8'h14, 1'b1, 1'b0, 8'h00);
    repeat (2) begin
      #1 check("bp_stall_full", bus.cpu_stall, 1'b1);
      @(negedge clk);
    end
    check("bp_level_full", bus.fifo_level, 3'd4);
    bus.tx_ready = 1'b1;
    #1 check("bp_stall_release", bus.cpu_stall, 1'b0);
    @(negedge clk);
    idle_inputs();
    check("bp_level_after", bus.fifo_level, 3'd4);
    for (int i = 0; i < 5; i++) expect_tx($sformatf("bp_out%0d", i), cb(8'h10 + 8'(i)));

    // Round-robin under continuous conflict; CPU holds a stalled write
    do_reset();
    c_cpu = '{8'h01, 8'h02, 8'h02, 8'h03};
    c_dbg = '{8'h61, 8'h61, 8'h62, 8'h62};
    c_grant_dbg = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(32'h2000, c_cpu[i], 1'b1, 1'b1, c_dbg[i]);
      #1;
      check($sformatf("rr%0d_stall", i), bus.cpu_stall, c_grant_dbg[i]);
      check($sformatf("rr%0d_dbg_ready", i), bus.dbg_ready, c_grant_dbg[i]);
      @(negedge clk);
    end
    idle_inputs();
    check("rr_level", bus.fifo_level, 3'd4);
    bus.tx_ready = 1'b1;
    expect_tx("rr_out0", cb(8'h01));
    expect_tx("rr_out1", 8'h61);
    expect_tx("rr_out2", cb(8'h02));
    expect_tx("rr_out3", 8'h62);

    // Reset in WAIT_DONE with three bytes still queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'h2000, 8'h20 + 8'(i), 1'b1, 1'b0, 8'h00);
      @(negedge clk);
    end
    idle_inputs();
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("rw_start", bus.tx_start, 1'b1);
    check("rw_level3", bus.fifo_level, 3'd3);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    check("rw_wait_start", bus.tx_start, 1'b0);
    rst = 1'b1;
    #1;
    check("rw_rst_start", bus.tx_start, 1'b0);
    check("rw_rst_level", bus.fifo_level, 3'd0);
    check("rw_rst_data", bus.tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx_start) cnt++;
    end
    check("rw_no_tx_after_reset", cnt, 0);

    // Reset while tx_start is high drops it immediately
    drive(32'h2000, 8'h33, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("rs_start", bus.tx_start, 1'b1);
    rst = 1'b1;
    #1;
    check("rs_rst_start", bus.tx_start, 1'b0);
    check("rs_rst_data", bus.tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
